// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Per-channel button pad conditioner (synchroniser, polarity fix,
//             debounce, press/release pulses, auto-repeat, sticky flags).
//  Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int                 NUM_BTN         = 6,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 250000,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 6'b001111,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 6'b000000,
    parameter int                 REPEAT_DELAY    = 12500000,
    parameter int                 REPEAT_PERIOD   = 2500000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic [NUM_BTN-1:0] btn_raw_i,
    input  logic [NUM_BTN-1:0] clr_i,
    output logic [NUM_BTN-1:0] btn_level_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o,
    output logic [NUM_BTN-1:0] btn_sticky_o
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   norm;
        logic [DB_W-1:0]        db_cnt_q;
        logic [DB_W-1:0]        db_cnt_d;
        logic                   level_q;
        logic                   level_d;
        logic                   press_q;
        logic                   press_d;
        logic                   release_q;
        logic                   release_d;
        logic                   sticky_q;
        logic                   sticky_d;
        logic                   accept;
        logic                   rpt_fire;

        assign norm = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];

        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            accept   = 1'b0;
            if (norm == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_d  = norm;
                db_cnt_d = '0;
                accept   = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
            press_d   = (accept & norm) | rpt_fire;
            release_d = accept & ~norm;
            // Sticky follows the registered pulse so a clear in the pulse cycle loses.
            sticky_d  = press_q | (sticky_q & ~clr_i[i]);
        end

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                sync_q    <= {SYNC_STAGES{ACTIVE_LOW_MASK[i]}};
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                sticky_q  <= 1'b0;
            end else begin
                sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw_i[i]};
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                sticky_q  <= sticky_d;
            end
        end

        if (REPEAT_MASK[i]) begin : g_rpt
            localparam int              RP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                                    REPEAT_DELAY : REPEAT_PERIOD;
            localparam int              RP_W      = $clog2(RP_MAX + 1);
            localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
            localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);

            logic [RP_W-1:0] rpt_cnt_q;
            logic [RP_W-1:0] rpt_cnt_d;
            logic            rpt_phase_q;
            logic            rpt_phase_d;

            // Phase 0 waits for the initial delay, phase 1 for each period.
            always_comb begin
                rpt_cnt_d   = '0;
                rpt_phase_d = 1'b0;
                rpt_fire    = 1'b0;
                if (level_q && !accept) begin
                    rpt_phase_d = rpt_phase_q;
                    rpt_cnt_d   = rpt_cnt_q + RP_W'(1);
                    if (rpt_cnt_d == (rpt_phase_q ? RP_PERIOD : RP_DELAY)) begin
                        rpt_fire    = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    rpt_cnt_q   <= '0;
                    rpt_phase_q <= 1'b0;
                end else begin
                    rpt_cnt_q   <= rpt_cnt_d;
                    rpt_phase_q <= rpt_phase_d;
                end
            end
        end else begin : g_no_rpt
            assign rpt_fire = 1'b0;
        end

        assign btn_level_o[i]   = level_q;
        assign btn_press_o[i]   = press_q;
        assign btn_release_o[i] = release_q;
        assign btn_sticky_o[i]  = sticky_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_btn_conditioner
//  Purpose  : Self-checking bench for btn_conditioner (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int         NB  = 4;
    localparam int         S   = 2;
    localparam int         D   = 4;
    localparam int         DLY = 10;
    localparam int         PER = 3;
    localparam logic [3:0] ALM = 4'b0010;
    localparam logic [3:0] RPM = 4'b0100;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw;
    logic [3:0] clr;
    logic [3:0] lvl_o;
    logic [3:0] press_o;
    logic [3:0] rel_o;
    logic [3:0] sticky_o;

    int tests = 0;
    int errs  = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN        (NB),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW_MASK(ALM),
        .REPEAT_MASK    (RPM),
        .REPEAT_DELAY   (DLY),
        .REPEAT_PERIOD  (PER)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .btn_raw_i    (raw),
        .clr_i        (clr),
        .btn_level_o  (lvl_o),
        .btn_press_o  (press_o),
        .btn_release_o(rel_o),
        .btn_sticky_o (sticky_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: raw samples reach the debouncer S edges later; a level
    // flips after D consecutive disagreeing samples; repeats are timed from
    // the accepting edge.
    logic [3:0] sq[$];
    logic [3:0] m_lvl    = '0;
    logic [3:0] m_press  = '0;
    logic [3:0] m_rel    = '0;
    logic [3:0] m_sticky = '0;
    logic [3:0] nv, np, nr, ns;
    int         run[NB];
    int         since[NB];

    initial begin
        for (int i = 0; i < NB; i++) begin
            run[i]   = 0;
            since[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sq.delete();
                m_lvl    = '0;
                m_press  = '0;
                m_rel    = '0;
                m_sticky = '0;
                for (int i = 0; i < NB; i++) begin
                    run[i]   = 0;
                    since[i] = 0;
                end
            end else begin
                nv = '0;
                if (sq.size() == S) nv = sq.pop_front() ^ ALM;
                sq.push_back(raw);
                ns = m_press | (m_sticky & ~clr);
                np = '0;
                nr = '0;
                for (int i = 0; i < NB; i++) begin
                    if (nv[i] != m_lvl[i]) begin
                        run[i]++;
                        if (run[i] == D) begin
                            run[i]   = 0;
                            m_lvl[i] = nv[i];
                            if (nv[i]) begin
                                np[i]    = 1'b1;
                                since[i] = 0;
                            end else begin
                                nr[i] = 1'b1;
                            end
                        end
                    end else begin
                        run[i] = 0;
                    end
                    if (m_lvl[i] && !np[i]) begin
                        since[i]++;
                        if (RPM[i] && (since[i] == DLY ||
                            (since[i] > DLY && (since[i] - DLY) % PER == 0)))
                            np[i] = 1'b1;
                    end
                end
                m_press  = np;
                m_rel    = nr;
                m_sticky = ns;
                #1;
                chk("model_level",   lvl_o,    m_lvl);
                chk("model_press",   press_o,  m_press);
                chk("model_release", rel_o,    m_rel);
                chk("model_sticky",  sticky_o, m_sticky);
                chk("press_and_release_together", press_o & rel_o, 4'b0);
            end
        end
    end

    logic [63:0] got0, got2, rel0, rel2;
    logic        found;
    int          hold[NB];

    initial begin
        raw = 4'b0010;
        clr = 4'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {lvl_o, press_o, rel_o, sticky_o}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("idle_outputs", {lvl_o, press_o, rel_o, sticky_o}, 16'h0);
        end

        // Channel 0 press: the sampling edge counts as edge 1.
        @(negedge clk);
        raw[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("ch0_level_early", lvl_o[0], 1'b0);
            if (k == 6) begin
                chk("ch0_level",     lvl_o[0],    1'b1);
                chk("ch0_press",     press_o[0],  1'b1);
                chk("ch0_sticky_lag", sticky_o[0], 1'b0);
            end
            if (k == 7) begin
                chk("ch0_press_one_cycle", press_o[0],  1'b0);
                chk("ch0_sticky_set",      sticky_o[0], 1'b1);
            end
        end
        @(negedge clk);
        raw[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("ch0_release_early", rel_o[0], 1'b0);
            if (k == 6) begin
                chk("ch0_release",     rel_o[0], 1'b1);
                chk("ch0_level_low",   lvl_o[0], 1'b0);
            end
            if (k == 7) chk("ch0_release_one_cycle", rel_o[0], 1'b0);
        end
        @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        #1;
        chk("ch0_sticky_cleared", sticky_o[0], 1'b0);

        // Clear in the pulse cycle loses; clear one cycle later wins.
        @(negedge clk);
        raw[0] = 1'b1;
        repeat (6) tick();
        chk("ch0_press_again", press_o[0], 1'b1);
        clr[0] = 1'b1;
        tick();
        chk("sticky_set_wins", sticky_o[0], 1'b1);
        tick();
        chk("sticky_clear_next", sticky_o[0], 1'b0);
        clr[0] = 1'b0;
        @(negedge clk);
        raw[0] = 1'b0;
        repeat (8) tick();

        // Channel 1 (active low): 3-cycle glitch rejected, 4-cycle press accepted.
        @(negedge clk);
        raw[1] = 1'b0;
        repeat (3) @(negedge clk);
        raw[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("ch1_glitch", {lvl_o[1], press_o[1], sticky_o[1]}, 3'b0);
        end
        @(negedge clk);
        raw[1] = 1'b0;
        repeat (6) tick();
        chk("ch1_level", lvl_o[1],   1'b1);
        chk("ch1_press", press_o[1], 1'b1);
        @(negedge clk);
        raw[1] = 1'b1;
        repeat (8) tick();

        // Repeat on channel 2 against single pulse on channel 0.
        @(negedge clk);
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (lvl_o[2]) found = 1'b1;
        end
        chk("ch2_accept_timeout", found, 1'b1);
        got0 = '0; got2 = '0; rel0 = '0; rel2 = '0;
        got0[0] = press_o[0];
        got2[0] = press_o[2];
        for (int off = 1; off <= 40; off++) begin
            tick();
            got0[off] = press_o[0];
            got2[off] = press_o[2];
            rel0[off] = rel_o[0];
            rel2[off] = rel_o[2];
            if (off == 25) begin
                raw[0] = 1'b0;
                raw[2] = 1'b0;
            end
        end
        chk("ch0_no_repeat", got0, 64'd1);
        chk("ch2_repeat_times", got2, (64'd1 << 0) | (64'd1 << 10) | (64'd1 << 13) |
            (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25) | (64'd1 << 28));
        chk("ch0_release_time", rel0, 64'd1 << 31);
        chk("ch2_release_time", rel2, 64'd1 << 31);

        // Reset mid-debounce with buttons still held.
        @(negedge clk);
        raw[3] = 1'b1;
        repeat (8) tick();
        chk("ch3_level", lvl_o[3], 1'b1);
        @(negedge clk);
        raw[0] = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {lvl_o, press_o, rel_o, sticky_o}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("post_reset_level_early", lvl_o, 4'b0000);
            if (k == 6) begin
                chk("post_reset_level", lvl_o,   4'b1001);
                chk("post_reset_press", press_o, 4'b1001);
            end
            if (k == 7) chk("post_reset_sticky", sticky_o, 4'b1001);
        end

        // Random phase checked by the model.
        for (int i = 0; i < NB; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = ~raw[i];
                    hold[i] = $urandom_range(1, (i == 2) ? 30 : 12);
                end else begin
                    hold[i]--;
                end
            end
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
